bd_chip_emu: RTL and testbench
==============================

Name: bd_chip_emu

Overview:
- Synthesizable model of the Braindrop chip's side of the BD link, for FPGA-only loopback builds and hardware-in-the-loop regression without silicon.
- Sinks downstream words (FPGA->BD, 21 b) and sources upstream words (BD->FPGA, 34 b).
- Ordinary words are echoed upstream with a sequence tag.
- A burst command word makes the block generate a programmable-length stream of upstream words.

Parameters:
- DEPTH, 4, downstream receive FIFO depth in words; power of 2, minimum 2.
- NBDdn, 21, downstream word width; fixed by the BD protocol.
- NBDup, 34, upstream word width; fixed by the BD protocol.
- BURST_OP, 5'h1F, value of BD_out_data[20:16] that marks a burst command.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high.
- BD_out_valid  in  1  FPGA presents a downstream word.
- BD_out_data  in  21  downstream word.
- BD_out_ready  out  1  emulator accepts the downstream word this cycle.
- BD_in_valid  out  1  emulator presents an upstream word.
- BD_in_data  out  34  upstream word.
- BD_in_ready  in  1  FPGA accepts the upstream word this cycle.

Behaviour:
- Interface clocking: one clock; reset is asynchronous and active-high. All state clears immediately on reset assertion.
- Reset values: BD_out_ready=0, BD_in_valid=0, BD_in_data=0, FIFO empty, seq=0, FSM=IDLE.
- Handshakes: a transfer occurs on the rising edge of clk when valid & ready are both high.
- BD_in_valid/BD_in_data come from an output register. Once valid rises, data is held stable until accepted. Valid never drops without a transfer, except on reset.
- BD_out_ready = !reset & (fifo_count < DEPTH). It is combinational from the count only, never from BD_out_valid.
- FIFO push and pop in the same cycle are both legal. When full, ready is low and there is no push, even if a pop happens that cycle.
- Upstream format:
  - BD_in_data[33:21] = seq, a 13-bit counter, +1 per upstream transfer, wraps 8191->0.
  - BD_in_data[20:0] = payload.
  - seq is sampled when the word is loaded into the output register.
- FSM states:
  - IDLE: output register empty or just accepted, and FIFO non-empty:
    - If head[20:16] != BURST_OP: pop the word, load {seq, head}, go to ECHO.
    - If head[20:16] == BURST_OP: pop the word, burst_len = head[15:0], idx = 0.
      - If burst_len == 0, stay IDLE with no output; the word is consumed silently.
      - Otherwise go to BURST.
  - ECHO: wait for the upstream transfer, then seq += 1 and go to IDLE. Back-to-back: if the FIFO is non-empty in the accept cycle, load the next word in that same cycle (throughput 1 word/clk).
  - BURST: load payload {5'h1E, idx[15:0]}. On each transfer: seq += 1, idx += 1.
    - When the transfer has idx == burst_len-1, go to IDLE.
    - Downstream FIFO accepts are still allowed during the burst, but no pops.
    - Bursts are not preemptible.
- Latency: a downstream word accepted at edge N has BD_in_valid high after edge N+1 when the FIFO was empty and the output is idle.
- Ordering: upstream words appear in downstream acceptance order. Burst words sit in place of their command.
- Reset mid-operation (burst or held valid): everything aborts; FIFO contents are lost; seq returns to 0.

Test Plan:
- Echo: send 21'h00_1234, BD_in_ready=1 -> one upstream word 34'h0_0001234 (seq 0); the next echo 21'h0ABCD gives seq 1.
- Backpressure: BD_in_ready=0, push 5 words -> first 4 (DEPTH) accepted plus 1 held in the output register, after which BD_out_ready=0. Raise ready -> all 5 emerge in order with seq 0..4, one per clock, BD_in_data stable while stalled.
- Burst: send 21'h1F_0003 -> upstream payloads 21'h1E_0000, 21'h1E_0001, 21'h1E_0002 with seq 0,1,2. No echo of the command.
- Zero burst: send 21'h1F_0000 then 21'h00_0007 -> single upstream word payload 21'h00_0007, seq 0.
- Seq wrap: 8193 echoes -> seq runs 8191 then 0, and the last word has seq 0.
- Reset mid-burst: 21'h1F_0100, assert reset after 10 transfers -> BD_in_valid and BD_out_ready drop asynchronously. After release, echo 21'h00_0001 returns seq 0.

Source files
------------

// File: rtl/bd_chip_emu.sv
// bd_chip_emu: Braindrop-side BD link emulator; echoes downstream words upstream with a seq tag and expands burst commands
// ports: clk, reset (async, active-high); BD_out_* = downstream sink (valid/data[20:0]/ready);
//        BD_in_* = upstream source (valid/data[33:0]/ready), data = {seq[12:0], payload[20:0]}
module bd_chip_emu #(
  parameter int DEPTH = 4,
  parameter int NBDdn = 21,
  parameter int NBDup = 34,
  parameter logic [4:0] BURST_OP = 5'h1F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BD_out_valid,
  input  logic [NBDdn-1:0] BD_out_data,
  output logic             BD_out_ready,
  output logic             BD_in_valid,
  output logic [NBDup-1:0] BD_in_data,
  input  logic             BD_in_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = NBDup - NBDdn;
  typedef enum logic [1:0] {IDLE, ECHO, BURST} state_t;
  state_t state_q, state_d;
  logic [NBDdn-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] seq_q, seq_d;
  logic [15:0] len_q, len_d, idx_q, idx_d;
  logic vld_q, vld_d;
  logic [NBDup-1:0] dat_q, dat_d;
  logic [NBDdn-1:0] head;
  logic push, pop, acc, is_burst, last;
  assign BD_out_ready = !reset && (cnt_q < CW'(DEPTH));
  assign BD_in_valid = vld_q;
  assign BD_in_data = dat_q;
  assign head = mem_q[rd_q];
  assign acc = vld_q & BD_in_ready;
  assign push = BD_out_valid & BD_out_ready;
  // the head is dispatched when idle, or in the same cycle an echo word is accepted
  assign pop = (cnt_q != '0) && (state_q == IDLE || (state_q == ECHO && acc));
  assign is_burst = head[NBDdn-1:NBDdn-5] == BURST_OP;
  assign last = idx_q == len_q - 16'd1;
  // a word loaded in an accept cycle must carry the already-advanced seq
  assign seq_d = seq_q + SW'(acc);
  assign wr_d = wr_q + AW'(push);
  assign rd_d = rd_q + AW'(pop);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = pop ? (!is_burst ? ECHO : (head[15:0] == 16'd0 ? IDLE : BURST))
            : (acc && (state_q == ECHO || (state_q == BURST && last))) ? IDLE : state_q;
  end
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    len_d = len_q;
    idx_d = idx_q;
    if (pop) begin
      len_d = head[15:0];
      idx_d = '0;
      vld_d = !is_burst || head[15:0] != 16'd0;
      dat_d = {seq_d, is_burst ? {5'h1E, 16'h0000} : head};
    end else if (acc) begin
      vld_d = state_q == BURST && !last;
      idx_d = idx_q + 16'd1;
      dat_d = {seq_d, 5'h1E, idx_q + 16'd1};
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
      len_q <= len_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= BD_out_data;
  end
endmodule

// File: tb/tb_bd_chip_emu.sv
// tb_bd_chip_emu: randomized and directed bench for bd_chip_emu against a stream-level reference model
module tb_bd_chip_emu;
  logic clk, reset, BD_out_valid, BD_out_ready, BD_in_valid, BD_in_ready;
  logic [20:0] BD_out_data;
  logic [33:0] BD_in_data;
  int errs, checks, n_up, base, accepted, k;
  logic [20:0] exp_q[$];
  logic [12:0] m_seq;
  logic [33:0] last_up, prev_d;
  logic prev_stalled, pushed;
  logic [20:0] w;
  logic [20:0] bp_words [5];

  bd_chip_emu dut (
    .clk(clk), .reset(reset),
    .BD_out_valid(BD_out_valid), .BD_out_data(BD_out_data), .BD_out_ready(BD_out_ready),
    .BD_in_valid(BD_in_valid), .BD_in_data(BD_in_data), .BD_in_ready(BD_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_push(input logic [20:0] d);
    if (d[20:16] == 5'h1F) begin
      for (int i = 0; i < int'(d[15:0]); i++) exp_q.push_back({5'h1E, 16'(i)});
    end else exp_q.push_back(d);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_seq = '0;
    prev_stalled = 1'b0;
  endtask

  task automatic cycle(input logic ov, input logic [20:0] od, input logic ir);
    @(negedge clk);
    BD_out_valid = ov;
    BD_out_data = od;
    BD_in_ready = ir;
    #1;
    if (prev_stalled) begin
      chk("hold_valid", {33'd0, BD_in_valid}, 34'd1);
      chk("hold_data", BD_in_data, prev_d);
    end
    prev_stalled = BD_in_valid && !BD_in_ready;
    prev_d = BD_in_data;
    if (BD_in_valid && BD_in_ready) begin
      if (exp_q.size() == 0) chk("up_extra", BD_in_data, 34'h3_FFFF_FFFF ^ BD_in_data);
      else chk("up_word", BD_in_data, {m_seq, exp_q.pop_front()});
      m_seq = m_seq + 13'd1;
      last_up = BD_in_data;
      n_up++;
    end
    pushed = BD_out_valid && BD_out_ready;
    if (pushed) model_push(od);
  endtask

  task automatic drain(input int bound);
    int c = 0;
    while ((exp_q.size() != 0 || BD_in_valid) && c < bound) begin
      cycle(1'b0, 21'd0, 1'b1);
      c++;
    end
    if (c >= bound) chk("drain_timeout", 34'd0, 34'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    BD_out_valid = 1'b0;
    BD_in_ready = 1'b0;
    #1;
    chk("rst_out_ready", {33'd0, BD_out_ready}, 34'd0);
    chk("rst_in_valid", {33'd0, BD_in_valid}, 34'd0);
    chk("rst_in_data", BD_in_data, 34'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    chk("rel_out_ready", {33'd0, BD_out_ready}, 34'd1);
  endtask

  initial begin
    errs = 0; checks = 0; n_up = 0;
    reset = 1'b1; BD_out_valid = 1'b0; BD_out_data = '0; BD_in_ready = 1'b0;
    model_clear();
    last_up = '0; prev_d = '0;
    bp_words = '{21'h00_0011, 21'h01_0022, 21'h02_0033, 21'h03_0044, 21'h04_0055};
    #12;
    chk("por_in_valid", {33'd0, BD_in_valid}, 34'd0);
    chk("por_in_data", BD_in_data, 34'd0);
    do_reset();
    // echo and latency
    base = n_up;
    cycle(1'b1, 21'h00_1234, 1'b1);
    cycle(1'b0, 21'd0, 1'b1);
    chk("lat_early", 34'(n_up - base), 34'd0);
    cycle(1'b0, 21'd0, 1'b1);
    chk("lat", 34'(n_up - base), 34'd1);
    chk("echo0", last_up, 34'h0_0001234);
    cycle(1'b1, 21'h0_ABCD, 1'b1);
    drain(20);
    chk("echo1", last_up, {13'd1, 21'h0_ABCD});
    // backpressure
    do_reset();
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(accepted < 5, bp_words[accepted < 5 ? accepted : 0], 1'b0);
      if (pushed) accepted++;
    end
    chk("bp_accepted", 34'(accepted), 34'd5);
    chk("bp_ready_low", {33'd0, BD_out_ready}, 34'd0);
    base = n_up;
    for (int i = 0; i < 5; i++) cycle(1'b0, 21'd0, 1'b1);
    chk("bp_rate", 34'(n_up - base), 34'd5);
    chk("bp_last", last_up, {13'd4, 21'h04_0055});
    drain(20);
    // burst
    do_reset();
    base = n_up;
    cycle(1'b1, 21'h1F_0003, 1'b1);
    drain(20);
    chk("burst_n", 34'(n_up - base), 34'd3);
    chk("burst_last", last_up, {13'd2, 21'h1E_0002});
    // zero-length burst
    do_reset();
    base = n_up;
    cycle(1'b1, 21'h1F_0000, 1'b1);
    cycle(1'b1, 21'h00_0007, 1'b1);
    drain(20);
    chk("zburst_n", 34'(n_up - base), 34'd1);
    chk("zburst_word", last_up, 34'h0_0000007);
    // seq wrap
    do_reset();
    base = n_up;
    accepted = 0;
    k = 0;
    while (accepted < 8193 && k < 9000) begin
      w = {5'(($urandom_range(0, 30))), 16'($urandom)};
      cycle(1'b1, w, 1'b1);
      if (pushed) accepted++;
      k++;
    end
    chk("wrap_accepted", 34'(accepted), 34'd8193);
    drain(50);
    chk("wrap_n", 34'(n_up - base), 34'd8193);
    chk("wrap_last_seq", {21'd0, last_up[33:21]}, 34'd0);
    // reset mid-burst
    do_reset();
    base = n_up;
    cycle(1'b1, 21'h1F_0100, 1'b1);
    k = 0;
    while (n_up - base < 10 && k < 50) begin
      cycle(1'b0, 21'd0, 1'b1);
      k++;
    end
    chk("mid_transfers", 34'(n_up - base), 34'd10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_in_valid", {33'd0, BD_in_valid}, 34'd0);
    chk("mid_out_ready", {33'd0, BD_out_ready}, 34'd0);
    chk("mid_in_data", BD_in_data, 34'd0);
    @(negedge clk);
    reset = 1'b0;
    BD_out_valid = 1'b0;
    model_clear();
    base = n_up;
    cycle(1'b1, 21'h00_0001, 1'b1);
    drain(20);
    chk("post_rst_n", 34'(n_up - base), 34'd1);
    chk("post_rst_echo", last_up, 34'h0_0000001);
    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) w = {5'h1F, 16'($urandom_range(0, 5))};
      else w = {5'(($urandom_range(0, 30))), 16'($urandom)};
      cycle($urandom_range(0, 1) == 1, w, $urandom_range(0, 9) < 7);
    end
    drain(200);
    chk("rand_drained", 34'(exp_q.size()), 34'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
